// File: rtl/window_scan_ctrl.sv
`default_nettype none
// ============================================================================
// window_scan_ctrl : raster sequencer for the 3x3 image/gauss window buffer.
// Optional macro WINDOW_SCAN_STATS_EN adds frame_cnt / drop_cnt outputs.
// Revision: 1.0
// ============================================================================
module window_scan_ctrl #(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int CLR_CYCLES = 2,
   parameter int CW         = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frame_start,
   input  logic          pix_valid,
   output logic          buf_clken,
   output logic          buf_aclr,
   output logic          win_valid,
   output logic [CW-1:0] win_col,
   output logic [CW-1:0] win_row,
   output logic          frame_done,
   output logic          frame_abort,
   output logic          err_overrun,
`ifdef WINDOW_SCAN_STATS_EN
   output logic [15:0]   frame_cnt,
   output logic [15:0]   drop_cnt,
`endif
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      ACTIVE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int             CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
   localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0]  ROW_LAST = CW'(IMG_H - 1);
   localparam logic [CW-1:0]  WIN_MIN  = CW'(2);

   state_t           state_q, state_d;
   logic [CW-1:0]    col_q, col_d;
   logic [CW-1:0]    row_q, row_d;
   logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic             buf_aclr_q, buf_aclr_d;
   logic             win_valid_q, win_valid_d;
   logic [CW-1:0]    win_col_q, win_col_d;
   logic [CW-1:0]    win_row_q, win_row_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_abort_q, frame_abort_d;
   logic             err_overrun_q, err_overrun_d;
   logic             pix_drop;

   // frame_start outranks a coincident pixel, so it gates the shift enable too
   assign buf_clken = pix_valid && !frame_start && (state_q == ACTIVE);

   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      row_d         = row_q;
      clr_cnt_d     = clr_cnt_q;
      buf_aclr_d    = 1'b0;
      win_valid_d   = 1'b0;
      win_col_d     = win_col_q;
      win_row_d     = win_row_q;
      frame_done_d  = 1'b0;
      frame_abort_d = 1'b0;
      err_overrun_d = err_overrun_q;
      pix_drop      = 1'b0;

      if (frame_start) begin
         state_d       = CLEAR;
         col_d         = '0;
         row_d         = '0;
         clr_cnt_d     = '0;
         buf_aclr_d    = 1'b1;
         err_overrun_d = 1'b0;
         frame_abort_d = (state_q == ACTIVE);
      end else begin
         case (state_q)
            CLEAR: begin
               if (clr_cnt_q == CLR_LAST) begin
                  state_d = ACTIVE;
               end else begin
                  clr_cnt_d  = clr_cnt_q + 1'b1;
                  buf_aclr_d = 1'b1;
               end
               if (pix_valid) begin
                  err_overrun_d = 1'b1;
                  pix_drop      = 1'b1;
               end
            end
            ACTIVE: begin
               if (pix_valid) begin
                  // window centre trails the newest pixel by one row and column
                  if ((col_q >= WIN_MIN) && (row_q >= WIN_MIN)) begin
                     win_valid_d = 1'b1;
                     win_col_d   = col_q - 1'b1;
                     win_row_d   = row_q - 1'b1;
                  end
                  if (col_q == COL_LAST) begin
                     col_d = '0;
                     if (row_q == ROW_LAST) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                     end else begin
                        row_d = row_q + 1'b1;
                     end
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end
            default: begin
               if (pix_valid) begin
                  err_overrun_d = 1'b1;
                  pix_drop      = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         col_q         <= '0;
         row_q         <= '0;
         clr_cnt_q     <= '0;
         buf_aclr_q    <= 1'b0;
         win_valid_q   <= 1'b0;
         win_col_q     <= '0;
         win_row_q     <= '0;
         frame_done_q  <= 1'b0;
         frame_abort_q <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         row_q         <= row_d;
         clr_cnt_q     <= clr_cnt_d;
         buf_aclr_q    <= buf_aclr_d;
         win_valid_q   <= win_valid_d;
         win_col_q     <= win_col_d;
         win_row_q     <= win_row_d;
         frame_done_q  <= frame_done_d;
         frame_abort_q <= frame_abort_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   assign buf_aclr    = buf_aclr_q;
   assign win_valid   = win_valid_q;
   assign win_col     = win_col_q;
   assign win_row     = win_row_q;
   assign frame_done  = frame_done_q;
   assign frame_abort = frame_abort_q;
   assign err_overrun = err_overrun_q;
   assign busy        = (state_q == CLEAR) || (state_q == ACTIVE);

`ifdef WINDOW_SCAN_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q + {15'd0, frame_done_d};
      drop_cnt_d  = drop_cnt_q;
      if (frame_start) begin
         drop_cnt_d = '0;
      end else if (pix_drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_window_scan_ctrl.sv
`default_nettype none
// Scoreboarded bench for window_scan_ctrl with an 8x4 frame and a 2-cycle clear.
module tb_window_scan_ctrl;
   localparam int W  = 8;
   localparam int H  = 4;
   localparam int CC = 2;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_start = 1'b0;
   logic          pix_valid = 1'b0;
   logic          buf_clken, buf_aclr, win_valid, frame_done, frame_abort, err_overrun, busy;
   logic [CW-1:0] win_col, win_row;
`ifdef WINDOW_SCAN_STATS_EN
   logic [15:0]   frame_cnt, drop_cnt;
`endif

   window_scan_ctrl #(.IMG_W(W), .IMG_H(H), .CLR_CYCLES(CC), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
      .buf_clken(buf_clken), .buf_aclr(buf_aclr), .win_valid(win_valid),
      .win_col(win_col), .win_row(win_row), .frame_done(frame_done),
      .frame_abort(frame_abort), .err_overrun(err_overrun),
`ifdef WINDOW_SCAN_STATS_EN
      .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [CW-1:0] r;
      logic          last;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   n_win = 0, n_done = 0, n_abort = 0, n_clken = 0, n_aclr = 0;
   int   s_win, s_done, s_abort, s_clken, s_aclr;
   int   bc, br;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      s_win = n_win; s_done = n_done; s_abort = n_abort; s_clken = n_clken; s_aclr = n_aclr;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (buf_clken) n_clken++;
            if (buf_aclr) n_aclr++;
            if (frame_done) n_done++;
            if (frame_abort) n_abort++;
            if (win_valid) begin
               n_win++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_win", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("win_col", win_col, e.c);
                  chk("win_row", win_row, e.r);
                  chk("done_with_win", frame_done, e.last);
               end
            end else if (frame_done) begin
               chk("done_without_win", 1, 0);
            end
         end
      end
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      bc = 0;
      br = 0;
   endtask

   // pixels only driven while the DUT is ACTIVE; bench tracks raster position
   task automatic send_pixels(input int n, input bit gaps);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         pix_valid = 1'b1;
         if (bc >= 2 && br >= 2) begin
            e.c = CW'(bc - 1);
            e.r = CW'(br - 1);
            e.last = (bc == W - 1) && (br == H - 1);
            exp_q.push_back(e);
         end
         if (bc == W - 1) begin
            bc = 0;
            br++;
         end else begin
            bc++;
         end
         tick();
         if (gaps) begin
            pix_valid = 1'b0;
            tick();
         end
      end
      pix_valid = 1'b0;
   endtask

   task automatic drain_check(input string tag, input int win, input int done,
                              input int clken, input int abort);
      repeat (3) tick();
      chk({tag, "_win_cnt"}, n_win - s_win, win);
      chk({tag, "_done_cnt"}, n_done - s_done, done);
      chk({tag, "_clken_cnt"}, n_clken - s_clken, clken);
      chk({tag, "_abort_cnt"}, n_abort - s_abort, abort);
      chk({tag, "_queue_left"}, exp_q.size(), 0);
   endtask

   initial begin
      fork
         monitor();
      join_none

      // reset state
      repeat (3) tick();
      chk("rst_outputs", {buf_clken, buf_aclr, win_valid, win_col, win_row, frame_done,
                          frame_abort, err_overrun, busy}, 0);
      rst_n = 1'b1;
      repeat (6) tick();

      // frame A: continuous, plus CLEAR timing
      snap();
      start_frame();
      chk("aclr_c1", buf_aclr, 1);
      chk("busy_c1", busy, 1);
      tick();
      chk("aclr_c2", buf_aclr, 1);
      tick();
      chk("aclr_active", buf_aclr, 0);
      chk("busy_active", busy, 1);
      send_pixels(32, 1'b0);
      drain_check("contig", 12, 1, 32, 0);
      chk("contig_aclr_cnt", n_aclr - s_aclr, 2);
      chk("busy_after_done", busy, 0);

      // frame B: alternating valid
      snap();
      start_frame();
      repeat (CC) tick();
      send_pixels(32, 1'b1);
      drain_check("gap", 12, 1, 32, 0);
`ifdef WINDOW_SCAN_STATS_EN
      chk("frame_cnt_2", frame_cnt, 2);
`endif

      // abort after 20 pixels, then a full frame
      snap();
      start_frame();
      repeat (CC) tick();
      send_pixels(20, 1'b0);
      start_frame();
      chk("abort_pulse", frame_abort, 1);
      chk("abort_aclr", buf_aclr, 1);
      repeat (CC) tick();
      send_pixels(32, 1'b0);
      drain_check("abort", 14, 1, 52, 1);

      // overrun in CLEAR and after DONE
      snap();
      start_frame();
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      chk("ovr_clear", err_overrun, 1);
      start_frame();
      chk("ovr_cleared1", err_overrun, 0);
      repeat (CC) tick();
      send_pixels(32, 1'b0);
      tick();
      pix_valid = 1'b1;
      repeat (3) tick();
      pix_valid = 1'b0;
      chk("ovr_done", err_overrun, 1);
      drain_check("ovr", 12, 1, 32, 0);
      start_frame();
      chk("ovr_cleared2", err_overrun, 0);

      // reset mid-frame
      repeat (CC) tick();
      send_pixels(16, 1'b0);
      pix_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {buf_clken, buf_aclr, win_valid, win_col, win_row, frame_done,
                             frame_abort, err_overrun, busy}, 0);
      pix_valid = 1'b0;
      repeat (2) tick();
      chk("midrst_queue", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
